// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG block front end.
//   seq_state_t   : sequencer FSM states
//   comp_t        : colour component of a block (Y / Cb / Cr)
//   BLK_SAMPLES   : samples in one 8x8 block
//   comp_of_block : maps a block position within an MCU to its component
package jpeg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  localparam int BLK_SAMPLES = 64;

  // Luma blocks come first in an MCU, then one Cb block, then one Cr block.
  function automatic comp_t comp_of_block(input logic [2:0] blk, input int luma_blocks);
    if (int'(blk) < luma_blocks)
      return COMP_Y;
    else if (int'(blk) == luma_blocks)
      return COMP_CB;
    else
      return COMP_CR;
  endfunction

endpackage

// File: rtl/jpeg_mcu_counter.sv
// Block / MCU position tracker for the block sequencer.
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : restart at block 0 of MCU 0 (frame start)
//   advance      : one block finished
//   frame_mcus   : MCUs in the current frame
//   block_idx    : block within the MCU, 0..LUMA_BLOCKS+1
//   mcu_idx      : current MCU
//   comp_id      : component of the current block
//   qtab_sel     : 0 = luma quant table, 1 = chroma quant table
//   last_block   : current block is the final block of the frame
module jpeg_mcu_counter
  import jpeg_pkg::*;
#(
  parameter int LUMA_BLOCKS = 4,
  parameter int MCU_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [MCU_W-1:0] frame_mcus,
  output logic [2:0]       block_idx,
  output logic [MCU_W-1:0] mcu_idx,
  output logic [1:0]       comp_id,
  output logic             qtab_sel,
  output logic             last_block
);

  localparam logic [2:0]       LAST_BLK = 3'(LUMA_BLOCKS + 1);
  localparam logic [MCU_W-1:0] MCU_ONE  = MCU_W'(1);

  comp_t comp;
  logic  last_in_mcu;

  assign last_in_mcu = (block_idx == LAST_BLK);
  assign last_block  = last_in_mcu && (mcu_idx == frame_mcus - MCU_ONE);

  // The frame's final block wraps both counters so the next frame starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_idx <= '0;
      mcu_idx   <= '0;
    end else if (clear) begin
      block_idx <= '0;
      mcu_idx   <= '0;
    end else if (advance) begin
      if (last_in_mcu) begin
        block_idx <= '0;
        mcu_idx   <= last_block ? '0 : mcu_idx + MCU_ONE;
      end else begin
        block_idx <= block_idx + 3'd1;
      end
    end
  end

  assign comp     = comp_of_block(block_idx, LUMA_BLOCKS);
  assign comp_id  = comp;
  assign qtab_sel = (comp != COMP_Y);

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Front-end controller for the JPEG block datapath. Gathers 64-sample blocks
// from a valid/ready source, writes them into the datapath block buffer,
// starts one datapath pass per block and tracks block/MCU position per frame.
//   clk, rst              : clock, asynchronous active-high reset
//   frame_start, cfg_mcus : start a frame of cfg_mcus MCUs (IDLE only)
//   s_valid/s_data/s_ready: sample stream, raster order within a block
//   dp_load/dp_addr/dp_data: block buffer write port
//   dp_start / dp_done    : per-block datapath handshake
//   comp_id, qtab_sel     : component and quant table of the current block
//   block_idx, mcu_idx    : position of the current block in the frame
//   busy, frame_done      : activity flag and end-of-frame pulse
module jpeg_block_sequencer
  import jpeg_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int LUMA_BLOCKS = 4,
  parameter int MCU_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [MCU_W-1:0]  cfg_mcus,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              dp_load,
  output logic [5:0]        dp_addr,
  output logic [DATA_W-1:0] dp_data,
  output logic              dp_start,
  input  logic              dp_done,
  output logic [1:0]        comp_id,
  output logic              qtab_sel,
  output logic [2:0]        block_idx,
  output logic [MCU_W-1:0]  mcu_idx,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [5:0] LAST_SAMPLE = 6'(BLK_SAMPLES - 1);

  seq_state_t       state, state_next;
  logic [5:0]       sample_cnt;
  logic [MCU_W-1:0] frame_mcus;
  logic             accept;
  logic             cnt_clear;
  logic             blk_advance;
  logic             last_block;

  assign s_ready    = (state == ST_LOAD);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign accept     = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Spurious frame_start / dp_done are ignored simply because only IDLE and
  // WAIT look at them.
  always_comb begin
    state_next  = state;
    cnt_clear   = 1'b0;
    blk_advance = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          if (cfg_mcus != '0) begin
            cnt_clear  = 1'b1;
            state_next = ST_LOAD;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (accept && (sample_cnt == LAST_SAMPLE)) state_next = ST_START;
      end
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        if (dp_done) begin
          blk_advance = 1'b1;
          state_next  = last_block ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The 6-bit sample counter wraps to 0 by itself on the 64th beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      frame_mcus <= '0;
    end else if (cnt_clear) begin
      sample_cnt <= '0;
      frame_mcus <= cfg_mcus;
    end else if (accept) begin
      sample_cnt <= sample_cnt + 6'd1;
    end
  end

  // Write port is registered one cycle behind the accept. dp_start is a
  // registered copy of START so it lands one cycle after the final write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_load  <= 1'b0;
      dp_addr  <= '0;
      dp_data  <= '0;
      dp_start <= 1'b0;
    end else begin
      dp_load  <= accept;
      dp_start <= (state == ST_START);
      if (accept) begin
        dp_addr <= sample_cnt;
        dp_data <= s_data;
      end
    end
  end

  jpeg_mcu_counter #(
    .LUMA_BLOCKS (LUMA_BLOCKS),
    .MCU_W       (MCU_W)
  ) u_mcu_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .advance    (blk_advance),
    .frame_mcus (frame_mcus),
    .block_idx  (block_idx),
    .mcu_idx    (mcu_idx),
    .comp_id    (comp_id),
    .qtab_sel   (qtab_sel),
    .last_block (last_block)
  );

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Self-checking bench for jpeg_block_sequencer: random sample source with
// gaps, a datapath responder with random latency, and a frame-level model
// that predicts every buffer write and block tag from the block ordinal.
module tb_jpeg_block_sequencer;

  localparam int DATA_W      = 8;
  localparam int LUMA_BLOCKS = 4;
  localparam int MCU_W       = 16;
  localparam int NBLK        = LUMA_BLOCKS + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic [MCU_W-1:0]  cfg_mcus;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              dp_load;
  logic [5:0]        dp_addr;
  logic [DATA_W-1:0] dp_data;
  logic              dp_start;
  logic              dp_done;
  logic [1:0]        comp_id;
  logic              qtab_sel;
  logic [2:0]        block_idx;
  logic [MCU_W-1:0]  mcu_idx;
  logic              busy;
  logic              frame_done;

  jpeg_block_sequencer #(
    .DATA_W      (DATA_W),
    .LUMA_BLOCKS (LUMA_BLOCKS),
    .MCU_W       (MCU_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .cfg_mcus    (cfg_mcus),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .dp_load     (dp_load),
    .dp_addr     (dp_addr),
    .dp_data     (dp_data),
    .dp_start    (dp_start),
    .dp_done     (dp_done),
    .comp_id     (comp_id),
    .qtab_sel    (qtab_sel),
    .block_idx   (block_idx),
    .mcu_idx     (mcu_idx),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Frame-level model state
  int                exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  int accepted, starts, dones, loads_in_blk, loads_total, frame_total, fd_seen;
  int resp_cnt, since_last, src_pct, lat_lo, lat_hi, fs_cfg;
  bit spur_en, fs_req, src_en, held, exp_ready_low, exp_ready_high;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    exp_addr_q.delete();
    exp_data_q.delete();
    accepted = 0; starts = 0; dones = 0; loads_in_blk = 0; loads_total = 0;
    fd_seen = 0; resp_cnt = 0; since_last = -1;
    held = 0; exp_ready_low = 0; exp_ready_high = 0; fs_req = 0; src_en = 0;
    s_valid = 0; dp_done = 0; frame_start = 0;
  endtask

  // One clock cycle: observe outputs at the falling edge, then drive the
  // inputs that the next rising edge will sample.
  task automatic applyStimulus();
    int blk;
    int exp_comp;
    @(negedge clk);
    if (since_last >= 0) since_last++;
    if (exp_ready_low) begin
      checkOutput("ready_after_64th", s_ready, 0);
      exp_ready_low = 0;
    end
    if (exp_ready_high) begin
      checkOutput("ready_after_done", s_ready, 1);
      exp_ready_high = 0;
    end
    if (dp_load) begin
      if (exp_data_q.size() == 0) begin
        checkOutput("load_unexpected", 1, 0);
      end else begin
        checkOutput("dp_addr", dp_addr, exp_addr_q.pop_front());
        checkOutput("dp_data", dp_data, exp_data_q.pop_front());
      end
      checkOutput("load_block_idx", block_idx, starts % NBLK);
      loads_in_blk++;
      loads_total++;
    end
    if (dp_start) begin
      blk      = starts % NBLK;
      exp_comp = (blk < LUMA_BLOCKS) ? 0 : ((blk == LUMA_BLOCKS) ? 1 : 2);
      checkOutput("loads_per_block", loads_in_blk, 64);
      checkOutput("start_latency", since_last, 2);
      checkOutput("comp_id", comp_id, exp_comp);
      checkOutput("qtab_sel", qtab_sel, (exp_comp != 0) ? 1 : 0);
      checkOutput("block_idx", block_idx, blk);
      checkOutput("mcu_idx", mcu_idx, starts / NBLK);
      starts++;
      loads_in_blk = 0;
      since_last   = -1;
      resp_cnt     = $urandom_range(lat_hi, lat_lo);
    end
    if (frame_done) begin
      fd_seen++;
      checkOutput("done_after_last", dones, frame_total);
    end

    // Datapath responder plus optional spurious pulses
    dp_done     = 1'b0;
    frame_start = 1'b0;
    if (resp_cnt > 0) begin
      if (spur_en && $urandom_range(3, 0) == 0) begin
        frame_start = 1'b1;
        cfg_mcus    = MCU_W'($urandom);
      end
      resp_cnt--;
      if (resp_cnt == 0) begin
        dp_done = 1'b1;
        dones++;
        exp_ready_high = (dones < frame_total);
      end
    end else if (spur_en && s_ready && $urandom_range(7, 0) == 0) begin
      dp_done = 1'b1;
    end
    if (fs_req) begin
      frame_start = 1'b1;
      cfg_mcus    = MCU_W'(fs_cfg);
      fs_req      = 0;
    end

    // Sample source: holds a beat until it is taken
    if (!src_en) begin
      s_valid = 1'b0;
      held    = 0;
    end else if (!held) begin
      s_valid = ($urandom_range(99, 0) < src_pct);
      s_data  = DATA_W'($urandom);
    end
    if (s_valid && s_ready) begin
      exp_addr_q.push_back(accepted % 64);
      exp_data_q.push_back(s_data);
      accepted++;
      if (accepted % 64 == 0) begin
        exp_ready_low = 1;
        since_last    = 0;
      end
      held = 0;
    end else begin
      held = s_valid;
    end
  endtask

  task automatic beginFrame(input int cfg, input int pct, input int lo, input int hi, input bit spur);
    exp_addr_q.delete();
    exp_data_q.delete();
    accepted = 0; starts = 0; dones = 0; loads_in_blk = 0; loads_total = 0; fd_seen = 0;
    frame_total = cfg * NBLK;
    src_pct = pct; lat_lo = lo; lat_hi = hi; spur_en = spur;
    fs_cfg = cfg; fs_req = 1; src_en = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("busy_after_start", busy, 1);
    checkOutput("frame_done_timing", frame_done, (cfg == 0) ? 1 : 0);
  endtask

  task automatic finishFrame();
    int budget;
    budget = frame_total * 400 + 20;
    while (fd_seen == 0 && budget > 0) begin
      applyStimulus();
      budget--;
    end
    if (fd_seen == 0) checkOutput("frame_timeout", 0, 1);
    src_en = 0;
    spur_en = 0;
    applyStimulus();
    checkOutput("frame_done_pulse", frame_done, 0);
    checkOutput("idle_after_frame", busy, 0);
    checkOutput("frame_done_count", fd_seen, 1);
    checkOutput("starts_per_frame", starts, frame_total);
    checkOutput("dones_per_frame", dones, frame_total);
    checkOutput("loads_per_frame", loads_total, frame_total * 64);
    checkOutput("loads_eq_accepted", loads_total, accepted);
    checkOutput("pending_writes", exp_data_q.size(), 0);
  endtask

  task automatic runFrame(input int cfg, input int pct, input int lo, input int hi, input bit spur);
    beginFrame(cfg, pct, lo, hi, spur);
    finishFrame();
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    cfg_mcus = '0;
    s_data = '0;
    spur_en = 0;
    frame_total = 0;
    src_pct = 100; lat_lo = 1; lat_hi = 1; fs_cfg = 0;
    resetModel();
    #3;
    checkOutput("reset_ctrl", {s_ready, dp_load, dp_start, busy, frame_done, qtab_sel, comp_id, block_idx}, 0);
    checkOutput("reset_data", {dp_addr, dp_data, mcu_idx}, 0);
    #9 rst = 1'b0;
    repeat (2) applyStimulus();

    // Reset in the middle of loading the first block
    beginFrame(2, 100, 5, 5, 0);
    budget = 200;
    while (loads_total < 20 && budget > 0) begin
      applyStimulus();
      budget--;
    end
    if (loads_total < 20) checkOutput("midload_timeout", loads_total, 20);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_ctrl", {s_ready, dp_load, dp_start, busy, frame_done, qtab_sel, comp_id, block_idx}, 0);
    checkOutput("midreset_data", {dp_addr, dp_data, mcu_idx}, 0);
    #1 rst = 1'b0;
    resetModel();
    repeat (4) applyStimulus();
    checkOutput("no_start_after_reset", starts, 0);
    checkOutput("no_done_after_reset", fd_seen, 0);
    checkOutput("idle_after_reset", busy, 0);

    // One MCU, continuous source, fixed datapath latency
    runFrame(1, 100, 5, 5, 0);
    // One MCU with source gaps and random latency (including first-cycle done)
    runFrame(1, 50, 1, 6, 0);
    // Three MCUs with gaps and spurious dp_done / frame_start
    runFrame(3, 50, 1, 6, 1);
    // Empty frame
    runFrame(0, 100, 1, 1, 0);
    // Random short frames
    for (int i = 0; i < 3; i++)
      runFrame($urandom_range(2, 1), $urandom_range(90, 30), 1, 8, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/jpeg_block_sequencer.md
# jpeg_block_sequencer

Front-end controller for the JPEG block datapath: gathers the incoming sample stream into 8x8 blocks and writes each block into the datapath's block buffer. It starts one transform/quantise pass per block, tags each block with its component and quantisation-table select, and counts blocks and MCUs per frame. It sits between the pixel source (valid/ready) and the DCT/quant/zigzag datapath (load/start/done).

## Interface
Parameters:
- DATA_W, 8, sample width
- LUMA_BLOCKS, 4, Y blocks per MCU (4:2:0)
- MCU_W, 16, width of MCU counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle start pulse; honoured only in IDLE
- cfg_mcus  in  MCU_W  MCUs in the frame; sampled on an accepted frame_start
- s_valid  in  1  sample valid
- s_data  in  DATA_W  sample, raster order within a block
- s_ready  out  1  sample accept; a beat transfers when s_valid and s_ready are both high
- dp_load  out  1  write strobe into the datapath block buffer
- dp_addr  out  6  write address, 0..63 = row*8+col
- dp_data  out  DATA_W  write data
- dp_start  out  1  one-cycle block start pulse
- dp_done  in  1  one-cycle block complete pulse from the datapath
- comp_id  out  2  0=Y, 1=Cb, 2=Cr for the current block
- qtab_sel  out  1  0 = luma table, 1 = chroma table
- block_idx  out  3  block within MCU, 0..LUMA_BLOCKS+1
- mcu_idx  out  MCU_W  current MCU, 0..cfg_mcus-1
- busy  out  1  high outside IDLE
- frame_done  out  1  one-cycle end-of-frame pulse

## Operation
- Blocks per MCU: NBLK = LUMA_BLOCKS+2.
- comp_id = 0 when block_idx < LUMA_BLOCKS, 1 when block_idx = LUMA_BLOCKS, 2 otherwise. qtab_sel = (comp_id != 0).
- States:
  - IDLE: wait for frame_start.
  - LOAD: accept 64 samples.
  - START: issue dp_start.
  - WAIT: wait for dp_done.
  - DONE: pulse frame_done.
- IDLE, on frame_start:
  - cfg_mcus != 0: latch cfg_mcus, clear counters, go to LOAD.
  - cfg_mcus == 0: go to DONE.
- LOAD: s_ready = 1. Each accepted beat increments the 6-bit sample counter. The beat with counter = 63 goes to START and wraps the counter to 0.
- START: one cycle, then WAIT.
- WAIT: s_ready = 0. dp_done advances the counters:
  - block_idx increments.
  - At NBLK-1, block_idx wraps to 0 and mcu_idx increments.
  - If this was the last block of the last MCU, go to DONE; otherwise go to LOAD.
- DONE: frame_done = 1 for one cycle, then IDLE.
- Ignored events:
  - frame_start outside IDLE.
  - dp_done outside WAIT.
  - s_valid while s_ready is low (data is held by the source, never dropped).
- comp_id, qtab_sel, block_idx and mcu_idx stay constant from the first beat of a block until the dp_done that ends it.

## Timing
- Reset values: state IDLE, all counters 0. Outputs s_ready, dp_load, dp_addr, dp_data, dp_start, comp_id, qtab_sel, block_idx, mcu_idx, busy and frame_done are all 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- Sample load path: a beat accepted at edge t gives dp_load = 1 with its dp_addr/dp_data during cycle t+1.
- The 64th beat accepted at t is followed by dp_start high during t+2, i.e. one cycle after its dp_load.
- s_ready falls in the cycle after the 64th accept, so no 65th beat is taken.
- Block turnaround: dp_done sampled at edge u gives s_ready high again from u+1, or frame_done high during u+1.
- Minimum block period: 64 + 2 + datapath latency cycles.
- A dp_done arriving in the first cycle of WAIT is accepted.
- A frame_start accepted at edge v gives busy high from v+1.
- An rst assertion mid-block returns to IDLE immediately and abandons the partial block; no dp_start or frame_done is issued for it.

## Structure
- Shared package jpeg_pkg holds:
  - state enum seq_state_t
  - comp_t (Y/CB/CR)
  - BLK_SAMPLES = 64
- A single sub-module, jpeg_mcu_counter, holds block_idx/mcu_idx, comp_id decode and last-block detect.
- The FSM and sample counter stay in the top level.

## Test plan
- Reset mid-LOAD after 20 beats → all outputs 0 at once; a new frame_start restarts at dp_addr 0, block_idx 0.
- cfg_mcus = 1, s_valid held high, dp_done 5 cycles after each dp_start → exactly 6 dp_start pulses with comp_id 0,0,0,0,1,2 and qtab_sel 0,0,0,0,1,1, then one frame_done; dp_addr runs 0..63 per block, and dp_data equals the input sample delayed one cycle.
- Random s_valid gaps (50%) → dp_load count equals accepted beats, and no dp_start before 64 loads.
- cfg_mcus = 3 → frame_done after 18 dp_done pulses; mcu_idx steps 0,1,2 and block_idx wraps at 5.
- cfg_mcus = 0 → frame_done in the second cycle after frame_start, and no dp_load or dp_start.
- Spurious inputs → no state change:
  - dp_done pulses during LOAD.
  - frame_start pulses during WAIT.
